// File: rtl/wbgpio.sv
// wbgpio: Wishbone GPIO peripheral with debounced inputs, per-bit edge
// interrupts (sticky write-1-to-clear status) and mask/value driven outputs.
module wbgpio #(
   parameter int               NIN         = 4,
   parameter int               NOUT        = 4,
   parameter int               DBW         = 20,
   parameter logic [DBW-1:0]   DEFAULT_DB  = DBW'(20'd1000000),
   parameter logic [NOUT-1:0]  DEFAULT_OUT = '0
) (
   input  logic            i_clk,
   input  logic            i_reset,
   input  logic            i_wb_cyc,
   input  logic            i_wb_stb,
   input  logic            i_wb_we,
   input  logic [1:0]      i_wb_addr,
   input  logic [31:0]     i_wb_data,
   output logic            o_wb_ack,
   output logic            o_wb_stall,
   output logic [31:0]     o_wb_data,
   input  logic [NIN-1:0]  i_gpio,
   output logic [NOUT-1:0] o_gpio,
   output logic            o_int
);

   logic [NIN-1:0]          s1_q, s1_d, s2_q, s2_d;
   logic [NIN-1:0]          deb_q, deb_d;
   logic [NIN-1:0][DBW-1:0] cnt_q, cnt_d;
   logic [NIN-1:0]          rise_q, rise_d, fall_q, fall_d;
   logic [NIN-1:0]          rien_q, rien_d, fien_q, fien_d;
   logic [NIN-1:0]          status_q, status_d;
   logic [NIN-1:0]          clr;
   logic [DBW-1:0]          lim_q, lim_d;
   logic [NOUT-1:0]         gpio_q, gpio_d;
   logic                    ack_q, ack_d;
   logic                    int_q, int_d;
   logic [31:0]             rdata_q, rdata_d;
   logic                    wr_en;
   logic                    unused_bus;

   // Bus cycle qualifier and upper write-data bits are deliberately ignored.
   assign unused_bus = ^{i_wb_cyc, i_wb_data};

   // Synchronise pins, then debounce each bit against the shared limit.
   always_comb begin
      s1_d  = i_gpio;
      s2_d  = s1_q;
      deb_d = deb_q;
      cnt_d = cnt_q;
      for (int i = 0; i < NIN; i++) begin
         if (s2_q[i] == deb_q[i]) begin
            cnt_d[i] = '0;
         end else if (cnt_q[i] >= lim_q) begin
            // >= (not ==) so a limit lowered mid-count still terminates.
            deb_d[i] = s2_q[i];
            cnt_d[i] = '0;
         end else begin
            cnt_d[i] = cnt_q[i] + DBW'(1);
         end
      end
      rise_d = deb_d & ~deb_q;
      fall_d = ~deb_d & deb_q;
   end

   // Register writes, W1C status with set-over-clear, and read-data mux.
   always_comb begin
      wr_en  = i_wb_stb && i_wb_we;
      gpio_d = gpio_q;
      rien_d = rien_q;
      fien_d = fien_q;
      lim_d  = lim_q;
      clr    = '0;
      if (wr_en) begin
         case (i_wb_addr)
            2'd0: begin
               for (int k = 0; k < NOUT; k++) begin
                  if (i_wb_data[16 + k]) gpio_d[k] = i_wb_data[k];
               end
            end
            2'd1: begin
               rien_d = i_wb_data[NIN-1:0];
               fien_d = i_wb_data[16 +: NIN];
            end
            2'd2:    clr   = i_wb_data[NIN-1:0];
            default: lim_d = i_wb_data[DBW-1:0];
         endcase
      end
      status_d = (status_q & ~clr) | (rise_q & rien_q) | (fall_q & fien_q);
      int_d    = |status_q;
      ack_d    = i_wb_stb;
      rdata_d  = rdata_q;
      if (i_wb_stb) begin
         rdata_d = '0;
         case (i_wb_addr)
            2'd0: begin
               rdata_d[16 +: NOUT] = gpio_q;
               rdata_d[0 +: NIN]   = deb_q;
            end
            2'd1: begin
               rdata_d[0 +: NIN]  = rien_q;
               rdata_d[16 +: NIN] = fien_q;
            end
            2'd2:    rdata_d[0 +: NIN] = status_q;
            default: rdata_d[0 +: DBW] = lim_q;
         endcase
      end
   end

   // All state, including debounce counts, is discarded on reset.
   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         s1_q     <= '0;
         s2_q     <= '0;
         deb_q    <= '0;
         cnt_q    <= '0;
         rise_q   <= '0;
         fall_q   <= '0;
         rien_q   <= '0;
         fien_q   <= '0;
         status_q <= '0;
         lim_q    <= DEFAULT_DB;
         gpio_q   <= DEFAULT_OUT;
         ack_q    <= 1'b0;
         int_q    <= 1'b0;
         rdata_q  <= '0;
      end else begin
         s1_q     <= s1_d;
         s2_q     <= s2_d;
         deb_q    <= deb_d;
         cnt_q    <= cnt_d;
         rise_q   <= rise_d;
         fall_q   <= fall_d;
         rien_q   <= rien_d;
         fien_q   <= fien_d;
         status_q <= status_d;
         lim_q    <= lim_d;
         gpio_q   <= gpio_d;
         ack_q    <= ack_d;
         int_q    <= int_d;
         rdata_q  <= rdata_d;
      end
   end

   assign o_wb_ack   = ack_q;
   assign o_wb_stall = 1'b0;
   assign o_wb_data  = rdata_q;
   assign o_gpio     = gpio_q;
   assign o_int      = int_q;

endmodule
